// File: rtl/func_dispatch.sv
// Operand FIFO and job sequencer feeding the `func` datapath (a^2 + cbrt(b)).
// Optional watchdog compiled in with FUNC_DISPATCH_TIMEOUT_EN.
module func_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_a,
  input  logic [7:0]                   in_b,
  output logic                         f_start,
  output logic [7:0]                   f_a,
  output logic [7:0]                   f_b,
  input  logic                         f_busy,
  input  logic [15:0]                  f_result,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_a,
  output logic [7:0]                   out_b,
  output logic [15:0]                  out_result,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
`ifdef FUNC_DISPATCH_TIMEOUT_EN
  ,
  output logic                         timeout_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]    state;
  logic [7:0]    mem_a [DEPTH];
  logic [7:0]    mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          done;
  logic          tmo_hit;

  assign in_ready = (fifo_count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == S_IDLE) && (fifo_count != '0) && !out_valid;
  assign done     = (state == S_WAIT_DONE) && !f_busy;

  // Operand storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef FUNC_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] tmo_cnt;

  // Restarts on entry to each wait state; counts every cycle spent waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == S_IDLE || state == S_ISSUE ||
                 (state == S_WAIT_BUSY && f_busy) || tmo_hit || done) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state == S_WAIT_BUSY || state == S_WAIT_DONE) &&
                   !done && (tmo_cnt == TW'(TIMEOUT-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_err <= 1'b0;
    end else if (tmo_hit) begin
      timeout_err <= 1'b1;
    end else if (out_valid && out_ready) begin
      timeout_err <= 1'b0;
    end
  end
`else
  // Watchdog absent: TIMEOUT has no effect in this build.
  assign tmo_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      f_start    <= 1'b0;
      f_a        <= '0;
      f_b        <= '0;
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_result <= '0;
    end else begin
      f_start <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            f_a     <= mem_a[rd_ptr];
            f_b     <= mem_b[rd_ptr];
            f_start <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (f_busy) state <= S_WAIT_DONE;
        end
        default: ;
      endcase
      // A capture can only occur while out_valid is low: no issue happens otherwise.
      if (done || tmo_hit) begin
        out_result <= done ? f_result : 16'hFFFF;
        out_a      <= f_a;
        out_b      <= f_b;
        out_valid  <= 1'b1;
        state      <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_func_dispatch.sv
// Directed bench for func_dispatch with a behavioural `func` responder.
module tb_func_dispatch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        f_start;
  logic [7:0]  f_a;
  logic [7:0]  f_b;
  logic        f_busy;
  logic [15:0] f_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic [15:0] out_result;
  logic [2:0]  fifo_count;
`ifdef FUNC_DISPATCH_TIMEOUT_EN
  logic        timeout_err;
`endif

  func_dispatch #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .f_start(f_start), .f_a(f_a), .f_b(f_b), .f_busy(f_busy), .f_result(f_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_result(out_result), .fifo_count(fifo_count)
`ifdef FUNC_DISPATCH_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r;
  } job_t;

  job_t got_q[$];
  job_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_start = 0;
  logic [7:0] st_a, st_b;
  int   lat = 3;
  bit   hang = 1'b0;

  function automatic logic [15:0] cbrt8(input logic [7:0] v);
    logic [15:0] r = 0;
    for (int i = 0; i <= 6; i++) if (i * i * i <= int'(v)) r = 16'(i);
    return r;
  endfunction

  // `func` responder: raises busy at the start pulse, drops it `lat` cycles later.
  initial begin
    int left = 0;
    logic [7:0] ra = 0, rb = 0;
    f_busy = 1'b0;
    f_result = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        f_busy = 1'b0;
        left = 0;
      end else if (f_start && !hang) begin
        ra = f_a;
        rb = f_b;
        f_busy = 1'b1;
        left = lat;
      end else if (left > 0) begin
        left--;
        if (left == 0) begin
          f_result = 16'(ra) * 16'(ra) + cbrt8(rb);
          f_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) got_q.push_back('{out_a, out_b, out_result});
      if (f_start) begin
        n_start++;
        st_a = f_a;
        st_b = f_b;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_job(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
    exp_q.push_back('{a, b, r});
  endtask

  task automatic drain_and_compare(input string tag);
    int k = 0;
    while (got_q.size() < exp_q.size() && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("%s_a%0d", tag, i), got_q[i].a, exp_q[i].a);
        chk($sformatf("%s_b%0d", tag, i), got_q[i].b, exp_q[i].b);
        chk($sformatf("%s_r%0d", tag, i), got_q[i].r, exp_q[i].r);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_f_start"}, f_start, 0);
    chk({tag, "_f_a"}, f_a, 0);
    chk({tag, "_f_b"}, f_b, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_a"}, out_a, 0);
    chk({tag, "_out_b"}, out_b, 0);
    chk({tag, "_out_result"}, out_result, 0);
    chk({tag, "_fifo_count"}, fifo_count, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    reset = 1'b1;
    @(posedge clk); #1;

    // Single job
    out_ready = 1'b1;
    n_start = 0;
    send(8'd3, 8'd8);
    expect_job(8'd3, 8'd8, 16'd11);
    drain_and_compare("single");
    chk("single_starts", n_start, 1);
    chk("single_fa", st_a, 3);
    chk("single_fb", st_b, 8);

    // Ordering, back-to-back
    n_start = 0;
    send(8'd4, 8'd27);
    send(8'd5, 8'd64);
    send(8'd255, 8'd255);
    send(8'd0, 8'd0);
    expect_job(8'd4, 8'd27, 16'd19);
    expect_job(8'd5, 8'd64, 16'd29);
    expect_job(8'd255, 8'd255, 16'd65031);
    expect_job(8'd0, 8'd0, 16'd0);
    drain_and_compare("order");
    chk("order_starts", n_start, 4);

    // Backpressure until full
    out_ready = 1'b0;
    send(8'd1, 8'd1);
    send(8'd2, 8'd8);
    send(8'd3, 8'd27);
    send(8'd10, 8'd64);
    send(8'd16, 8'd125);
    repeat (30) @(posedge clk);
    #1;
    in_a = 8'd7;
    in_b = 8'd0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_count", fifo_count, 4);
    chk("full_out_valid", out_valid, 1);
    chk("full_out_result", out_result, 2);
    chk("full_out_a", out_a, 1);
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("full_release", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_job(8'd1, 8'd1, 16'd2);
    expect_job(8'd2, 8'd8, 16'd6);
    expect_job(8'd3, 8'd27, 16'd12);
    expect_job(8'd10, 8'd64, 16'd104);
    expect_job(8'd16, 8'd125, 16'd261);
    expect_job(8'd7, 8'd0, 16'd49);
    drain_and_compare("full");

    // Push coinciding with pop
    out_ready = 1'b0;
    send(8'd9, 8'd1);
    repeat (20) @(posedge clk);
    #1;
    send(8'd2, 8'd27);
    send(8'd6, 8'd8);
    chk("pp_count_before", fifo_count, 2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("pp_drained", out_valid, 0);
    in_a = 8'd4;
    in_b = 8'd64;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pp_count_after", fifo_count, 2);
    expect_job(8'd9, 8'd1, 16'd82);
    expect_job(8'd2, 8'd27, 16'd7);
    expect_job(8'd6, 8'd8, 16'd38);
    expect_job(8'd4, 8'd64, 16'd20);
    drain_and_compare("pp");

    // Reset while a job is in flight
    lat = 10;
    send(8'd1, 8'd8);
    send(8'd2, 8'd8);
    send(8'd3, 8'd8);
    send(8'd4, 8'd8);
    n = 0;
    while (!f_busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("mid_count", fifo_count, 3);
    chk("mid_busy", f_busy, 1);
    reset = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    got_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    lat = 3;
    send(8'd1, 8'd1);
    expect_job(8'd1, 8'd1, 16'd2);
    drain_and_compare("post_rst");

`ifdef FUNC_DISPATCH_TIMEOUT_EN
    hang = 1'b1;
    out_ready = 1'b0;
    n_start = 0;
    send(8'd5, 8'd8);
    n = 0;
    while (n_start == 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tmo_cycles", n, 16);
    chk("tmo_result", out_result, 16'hFFFF);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_a", out_a, 5);
    chk("tmo_b", out_b, 8);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("tmo_err_clr", timeout_err, 0);
    chk("tmo_valid_clr", out_valid, 0);
    hang = 1'b0;
    got_q.delete();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/func_dispatch.md
Name: func_dispatch

Overview:
- Upstream feeder for the `func` datapath, which computes a^2 + cbrt(b).
- Accepts operand pairs (a,b) on a valid/ready stream and buffers them in a FIFO.
- Issues each pair to `func` using its start/busy handshake, then captures the 16-bit result.
- Presents {a, b, result} on a registered valid/ready output stream, keeping per-job operands attached to results.

Parameters:
- DEPTH, 4: operand FIFO entries; power of two, >= 2.
- TIMEOUT, 1024: watchdog limit in cycles; used only when the optional feature is compiled in.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous active-low reset (0 = reset); shared with `func`.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  FIFO can accept; equals !full.
- in_a  input  8  operand a.
- in_b  input  8  operand b.
- f_start  output  1  one-cycle start pulse to `func`.
- f_a  output  8  registered operand a to `func`.
- f_b  output  8  registered operand b to `func`.
- f_busy  input  1  `func` busy flag.
- f_result  input  16  `func` result; valid when f_busy falls.
- out_valid  output  1  result register holds a job.
- out_ready  input  1  consumer accepts.
- out_a  output  8  operand a of held job.
- out_b  output  8  operand b of held job.
- out_result  output  16  a^2 + cbrt(b) of held job.
- fifo_count  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, any time): all state is cleared.
  - Outputs: in_ready=1, f_start=0, f_a=0, f_b=0, out_valid=0, out_a=0, out_b=0, out_result=0, fifo_count=0, FSM=IDLE.
  - FIFO pointers are zeroed; in-flight and buffered jobs are discarded.
- FIFO push: in_valid & in_ready at an edge. in_ready depends only on full, never on a same-cycle pop.
- FIFO pop: only on the IDLE->ISSUE transition.
- Simultaneous push and pop: both occur; fifo_count is unchanged.
- Empty FIFO: no bypass. A pair pushed at edge k is poppable no earlier than edge k+1.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE -> ISSUE when fifo_count!=0 and out_valid==0. On this edge the FIFO head is loaded into f_a/f_b and popped.
  - ISSUE: f_start=1 for exactly this one cycle. Always -> WAIT_BUSY.
  - WAIT_BUSY -> WAIT_DONE on the first edge with f_busy==1.
  - WAIT_DONE -> IDLE on the first edge with f_busy==0. On that edge: out_result<=f_result, out_a<=f_a, out_b<=f_b, out_valid<=1.
- f_a and f_b are held stable from ISSUE until the capture edge.
- Output: out_valid falls on an edge with out_valid & out_ready. Output fields are stable while out_valid=1 and out_ready=0.
- No new job is issued while out_valid=1. A job finishing in the cycle its predecessor is being drained cannot occur.
- Minimum issue-to-output latency = 2 + (`func` busy cycles) + 1.
- No arithmetic is performed here; widths pass through unchanged.

Optional Feature:
- Macro: FUNC_DISPATCH_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_BUSY and in WAIT_DONE, reset on each state entry.
  - Reaching TIMEOUT forces a capture: out_result=16'hFFFF, out_a/out_b=job operands, out_valid=1, FSM->IDLE.
  - Adds an output port `timeout_err` (1 bit), set at that capture. It is cleared by reset or on the out_valid&out_ready edge of that job.
- Undefined: no counter and no `timeout_err` port; the FSM waits indefinitely.

Test Plan:
- Single job: push (3,8), out_ready=1 -> one f_start pulse with f_a=3, f_b=8; then out_valid with out_result=11, out_a=3, out_b=8.
- Ordering: push (4,27),(5,64),(255,255),(0,0) back-to-back, out_ready=1 -> results 19, 29, 65031, 0 in order; exactly four f_start pulses.
- Backpressure/full: DEPTH=4, out_ready=0, offer 6 pairs -> five accepted, in_ready=0, fifo_count=4, out_valid held with the first result.
  - Then out_ready=1 -> in_ready=1 next cycle; all 6 results drain in order.
- Simultaneous push/pop: fifo_count=2 in IDLE with a push at the pop edge -> fifo_count stays 2; no entry lost or duplicated.
- Reset mid-operation: drop reset in WAIT_DONE with 3 jobs buffered -> all outputs are at reset values immediately; after release, push (1,1) -> result 2.
- With FUNC_DISPATCH_TIMEOUT_EN and TIMEOUT=16: hold f_busy=0 after start -> at cycle 16 out_valid=1, out_result=16'hFFFF, timeout_err=1; it clears on handshake.
